// File: rtl/register_triple_out.sv
// Captures one value and hands it to up to three destination buses in fixed
// priority order (0, 1, 2), each through its own valid/ack handshake.
module register_triple_out #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic [2:0]       dest_mask,
    output logic             load_ready,
    output logic [WIDTH-1:0] data_q,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic             valid0,
    output logic             valid1,
    output logic             valid2,
    input  logic             ack0,
    input  logic             ack1,
    input  logic             ack2,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } state_t;

    localparam logic       TO_EN   = (TIMEOUT > 0);
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WIDTH-1:0] data_d;
    logic [2:0]       active;
    logic             ack_hit;
    logic             expire;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One-hot of the lowest pending destination; empty outside DELIVER.
    always_comb begin
        active = 3'b000;
        if (state_q == DELIVER) begin
            if (pending_q[0])      active = 3'b001;
            else if (pending_q[1]) active = 3'b010;
            else if (pending_q[2]) active = 3'b100;
        end
    end

    assign ack_hit = |(active & {ack2, ack1, ack0});
    // An ack in the expiry cycle wins over the timeout.
    assign expire  = TO_EN && (state_q == DELIVER) && (cnt_q == TO_LAST) && !ack_hit;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (load) begin
                data_d    = data_in;
                pending_d = dest_mask;
                cnt_d     = 8'd0;
                if (dest_mask != 3'b000) state_d = DELIVER;
            end
        end else begin
            if (ack_hit || expire) begin
                pending_d     = pending_q & ~active;
                cnt_d         = 8'd0;
                timeout_err_d = expire;
                if (pending_d == 3'b000) state_d = IDLE;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= 3'b000;
            data_q        <= '0;
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign valid0      = active[0];
    assign valid1      = active[1];
    assign valid2      = active[2];
    assign data_out0   = active[0] ? data_q : '0;
    assign data_out1   = active[1] ? data_q : '0;
    assign data_out2   = active[2] ? data_q : '0;
    assign busy        = (state_q == DELIVER);
    assign load_ready  = (state_q == IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_register_triple_out.sv
// Bench for register_triple_out: two instances (no timeout, timeout of 3)
// driven in parallel and compared every cycle with a queue-style delivery model.
module tb_register_triple_out;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load = 1'b0;
    logic [2:0] dest_mask = 3'b000;
    logic       ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;

    logic       load_ready_a, busy_a, timeout_err_a, valid0_a, valid1_a, valid2_a;
    logic [7:0] data_q_a, data_out0_a, data_out1_a, data_out2_a;
    logic       load_ready_b, busy_b, timeout_err_b, valid0_b, valid1_b, valid2_b;
    logic [7:0] data_q_b, data_out0_b, data_out1_b, data_out2_b;

    int n_chk  = 0;
    int n_fail = 0;
    int vcnt_b = 0;
    int errcnt_b = 0;

    always #5 clk = ~clk;

    register_triple_out #(.WIDTH(8), .TIMEOUT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .dest_mask(dest_mask),
        .load_ready(load_ready_a), .data_q(data_q_a),
        .data_out0(data_out0_a), .data_out1(data_out1_a), .data_out2(data_out2_a),
        .valid0(valid0_a), .valid1(valid1_a), .valid2(valid2_a),
        .ack0(ack0), .ack1(ack1), .ack2(ack2),
        .busy(busy_a), .timeout_err(timeout_err_a));

    register_triple_out #(.WIDTH(8), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .dest_mask(dest_mask),
        .load_ready(load_ready_b), .data_q(data_q_b),
        .data_out0(data_out0_b), .data_out1(data_out1_b), .data_out2(data_out2_b),
        .valid0(valid0_b), .valid1(valid1_b), .valid2(valid2_b),
        .ack0(ack0), .ack1(ack1), .ack2(ack2),
        .busy(busy_b), .timeout_err(timeout_err_b));

    logic [2:0]  o_vld[2];
    logic [23:0] o_dout[2];
    logic [7:0]  o_dq[2];
    logic [2:0]  o_ctl[2];
    assign o_vld[0]  = {valid2_a, valid1_a, valid0_a};
    assign o_vld[1]  = {valid2_b, valid1_b, valid0_b};
    assign o_dout[0] = {data_out2_a, data_out1_a, data_out0_a};
    assign o_dout[1] = {data_out2_b, data_out1_b, data_out0_b};
    assign o_dq[0]   = data_q_a;
    assign o_dq[1]   = data_q_b;
    assign o_ctl[0]  = {busy_a, load_ready_a, timeout_err_a};
    assign o_ctl[1]  = {busy_b, load_ready_b, timeout_err_b};

    // Model: list of destinations still to serve, a head index and a stall count.
    int         to_of[2] = '{0, 3};
    bit         m_idle[2];
    logic [7:0] m_data[2];
    int         m_dst[2][3];
    int         m_n[2];
    int         m_head[2];
    int         m_wait[2];
    bit         m_err[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idle[i] = 1'b1;
            m_data[i] = 8'h00;
            m_n[i]    = 0;
            m_head[i] = 0;
            m_wait[i] = 0;
            m_err[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit ld, input logic [7:0] d,
                              input logic [2:0] m, input logic [2:0] a);
        bit nerr;
        int cur;
        nerr = 1'b0;
        if (m_idle[i]) begin
            if (ld) begin
                m_data[i] = d;
                m_n[i] = 0;
                for (int k = 0; k < 3; k++)
                    if (m[k]) begin
                        m_dst[i][m_n[i]] = k;
                        m_n[i]++;
                    end
                m_head[i] = 0;
                m_wait[i] = 0;
                m_idle[i] = (m_n[i] == 0);
            end
        end else begin
            cur = m_dst[i][m_head[i]];
            if (a[cur]) begin
                m_head[i]++;
                m_wait[i] = 0;
            end else if (to_of[i] > 0 && m_wait[i] + 1 >= to_of[i]) begin
                m_head[i]++;
                m_wait[i] = 0;
                nerr = 1'b1;
            end else if (m_wait[i] < 255) begin
                m_wait[i]++;
            end
            if (m_head[i] == m_n[i]) m_idle[i] = 1'b1;
        end
        m_err[i] = nerr;
    endtask

    task automatic check_all();
        logic [2:0]  ev;
        logic [23:0] ed;
        for (int i = 0; i < 2; i++) begin
            ev = m_idle[i] ? 3'b000 : (3'b001 << m_dst[i][m_head[i]]);
            ed = {ev[2] ? m_data[i] : 8'h00, ev[1] ? m_data[i] : 8'h00, ev[0] ? m_data[i] : 8'h00};
            check_eq($sformatf("valid_i%0d", i), 32'(o_vld[i]), 32'(ev));
            check_eq($sformatf("dout_i%0d", i), 32'(o_dout[i]), 32'(ed));
            check_eq($sformatf("data_q_i%0d", i), 32'(o_dq[i]), 32'(m_data[i]));
            check_eq($sformatf("busy_ready_err_i%0d", i), 32'(o_ctl[i]),
                     32'({!m_idle[i], m_idle[i], m_err[i]}));
        end
        if (valid1_b) vcnt_b++;
        if (timeout_err_b) errcnt_b++;
    endtask

    task automatic step(input bit ld, input logic [7:0] d, input logic [2:0] m, input logic [2:0] a);
        load = ld;
        data_in = d;
        dest_mask = m;
        {ack2, ack1, ack0} = a;
        model_step(0, ld, d, m, a);
        model_step(1, ld, d, m, a);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check_eq("reset_load_ready", 32'(load_ready_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two of three destinations, acks always ready
        step(1'b1, 8'hA5, 3'b101, 3'b111);
        check_eq("s1_dout0", 32'(data_out0_a), 32'hA5);
        step(1'b0, 8'h00, 3'b000, 3'b111);
        check_eq("s1_dout2", 32'({valid2_a, data_out2_a}), 32'h1A5);
        step(1'b0, 8'h00, 3'b000, 3'b111);
        check_eq("s1_ready", 32'(load_ready_a), 32'd1);

        // Empty mask is a plain register update
        step(1'b1, 8'h3C, 3'b000, 3'b000);
        check_eq("s2_dq", 32'({busy_a, data_q_a}), 32'h03C);

        // Stall on destination 1, loads during the stall ignored
        step(1'b1, 8'h5A, 3'b111, 3'b101);
        step(1'b0, 8'h00, 3'b000, 3'b101);
        repeat (4) begin
            step(1'b1, 8'hFF, 3'b111, 3'b101);
            check_eq("s3_hold", 32'({valid1_a, data_out1_a, data_q_a}), 32'h15A5A);
        end
        repeat (6) step(1'b0, 8'h00, 3'b000, 3'b111);

        // Timeout on destination 1 (instance with TIMEOUT=3)
        vcnt_b = 0;
        errcnt_b = 0;
        step(1'b1, 8'h77, 3'b010, 3'b000);
        repeat (4) step(1'b0, 8'h00, 3'b000, 3'b000);
        check_eq("s4_valid_cycles", vcnt_b, 3);
        check_eq("s4_err_pulses", errcnt_b, 1);
        check_eq("s4_ready", 32'(load_ready_b), 32'd1);
        step(1'b0, 8'h00, 3'b000, 3'b010);

        // Ack on the expiry cycle counts as success
        vcnt_b = 0;
        errcnt_b = 0;
        step(1'b1, 8'h88, 3'b010, 3'b000);
        step(1'b0, 8'h00, 3'b000, 3'b000);
        step(1'b0, 8'h00, 3'b000, 3'b000);
        step(1'b0, 8'h00, 3'b000, 3'b010);
        repeat (2) step(1'b0, 8'h00, 3'b000, 3'b000);
        check_eq("s5_valid_cycles", vcnt_b, 3);
        check_eq("s5_err_pulses", errcnt_b, 0);

        // Reset during delivery
        step(1'b1, 8'h5A, 3'b111, 3'b000);
        step(1'b0, 8'h00, 3'b000, 3'b001);
        check_eq("s6_pre_valid1", 32'(valid1_a), 32'd1);
        async_reset();
        check_eq("s6_rst_outs", 32'({valid1_a, data_out1_a, load_ready_a}), 32'h001);
        step(1'b1, 8'h12, 3'b111, 3'b000);
        check_eq("s6_restart", 32'({valid0_a, data_out0_a}), 32'h112);
        repeat (4) step(1'b0, 8'h00, 3'b000, 3'b111);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 2) == 0, 8'($urandom), 3'($urandom),
                     {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
